// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: pixel-tick divider, x/y counters,
// line/frame strobes and a tick-aligned delay line on the sync/blank flags.
module vga_timing_gen #(
  parameter int H_DISPLAY  = 640,
  parameter int H_FRONT    = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BACK     = 48,
  parameter int V_DISPLAY  = 480,
  parameter int V_FRONT    = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BACK     = 33,
  parameter bit HSYNC_POL  = 1'b0,
  parameter bit VSYNC_POL  = 1'b0,
  parameter int CLK_DIV    = 1,
  parameter int PIPE_DELAY = 1,
  parameter int CW         = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  output logic          p_tick,
  output logic [CW-1:0] pixel_x,
  output logic [CW-1:0] pixel_y,
  output logic          hsync,
  output logic          vsync,
  output logic          video_on,
  output logic          line_start,
  output logic          frame_start,
  output logic [15:0]   frame_count
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_VIS    = CW'(H_DISPLAY);
  localparam logic [CW-1:0] V_VIS    = CW'(V_DISPLAY);
  localparam logic [CW-1:0] HS_FIRST = CW'(H_DISPLAY + H_FRONT);
  localparam logic [CW-1:0] HS_LAST  = CW'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [CW-1:0] VS_FIRST = CW'(V_DISPLAY + V_FRONT);
  localparam logic [CW-1:0] VS_LAST  = CW'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  // Inactive sync levels with blanking; also what every delay stage resets to.
  localparam logic [2:0] IDLE_FLAGS = {~HSYNC_POL, ~VSYNC_POL, 1'b0};

  logic [DW-1:0] div;
  logic          h_last;
  logic          v_last;
  logic          h_act;
  logic          v_act;
  logic          vis;
  logic [2:0]    flags_p0;
  logic [2:0]    flags_p [PIPE_DELAY];

  assign p_tick      = enable & ~reset & (div == DIV_LAST);
  assign h_last      = (pixel_x == H_LAST);
  assign v_last      = (pixel_y == V_LAST);
  assign line_start  = p_tick & (pixel_x == '0);
  assign frame_start = line_start & (pixel_y == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div <= '0;
    end else if (enable) begin
      div <= (div == DIV_LAST) ? '0 : div + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pixel_x     <= '0;
      pixel_y     <= '0;
      frame_count <= '0;
    end else if (p_tick) begin
      pixel_x <= h_last ? '0 : pixel_x + 1'b1;
      if (h_last) begin
        pixel_y <= v_last ? '0 : pixel_y + 1'b1;
        if (v_last) begin
          frame_count <= frame_count + 16'd1;
        end
      end
    end
  end

  always_comb begin
    h_act    = (pixel_x >= HS_FIRST) && (pixel_x <= HS_LAST);
    v_act    = (pixel_y >= VS_FIRST) && (pixel_y <= VS_LAST);
    vis      = (pixel_x < H_VIS) && (pixel_y < V_VIS);
    flags_p0 = {h_act ^ ~HSYNC_POL, v_act ^ ~VSYNC_POL, vis};
  end

  // Delay line advances in pixel ticks so outputs trail the counters by PIPE_DELAY ticks.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < PIPE_DELAY; i++) begin
        flags_p[i] <= IDLE_FLAGS;
      end
    end else if (p_tick) begin
      flags_p[0] <= flags_p0;
      for (int i = 1; i < PIPE_DELAY; i++) begin
        flags_p[i] <= flags_p[i-1];
      end
    end
  end

  assign {hsync, vsync, video_on} = flags_p[PIPE_DELAY-1];

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen on a shrunken 15x8 raster: one instance with
// tick-per-clk and single-stage delay, one with a /3 divider, 3-stage delay, active-high syncs.
module tb_vga_timing_gen;

  localparam int CW = 5;

  typedef struct {
    int n;
    int x;
    int y;
    int pt;
    int hs;
    int vs;
    int vo;
    int ls;
    int fs;
    int fc;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b1;

  logic          pt_a, hs_a, vs_a, vo_a, ls_a, fs_a;
  logic [CW-1:0] x_a, y_a;
  logic [15:0]   fc_a;
  logic          pt_b, hs_b, vs_b, vo_b, ls_b, fs_b;
  logic [CW-1:0] x_b, y_b;
  logic [15:0]   fc_b;

  int n_cmp = 0;
  int n_bad = 0;
  int edges = 0;

  vec_t tbl_a[$];
  vec_t tbl_b[$];

  always #5 clk = ~clk;

  vga_timing_gen #(
    .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .CLK_DIV(1), .PIPE_DELAY(1), .CW(CW)
  ) dut_a (
    .clk(clk), .reset(reset), .enable(enable), .p_tick(pt_a),
    .pixel_x(x_a), .pixel_y(y_a), .hsync(hs_a), .vsync(vs_a), .video_on(vo_a),
    .line_start(ls_a), .frame_start(fs_a), .frame_count(fc_a)
  );

  vga_timing_gen #(
    .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .CLK_DIV(3), .PIPE_DELAY(3), .CW(CW)
  ) dut_b (
    .clk(clk), .reset(reset), .enable(enable), .p_tick(pt_b),
    .pixel_x(x_b), .pixel_y(y_b), .hsync(hs_b), .vsync(vs_b), .video_on(vo_b),
    .line_start(ls_b), .frame_start(fs_b), .frame_count(fc_b)
  );

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #2;
    if (enable && !reset) edges++;
  endtask

  task automatic go_to(input int n);
    while (edges < n) adv();
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    enable = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b0;
    edges = 0;
    #1;
  endtask

  task automatic chk_a(input vec_t v);
    chk($sformatf("a.x@%0d", v.n), int'(x_a), v.x);
    chk($sformatf("a.y@%0d", v.n), int'(y_a), v.y);
    chk($sformatf("a.p_tick@%0d", v.n), int'(pt_a), v.pt);
    chk($sformatf("a.hsync@%0d", v.n), int'(hs_a), v.hs);
    chk($sformatf("a.vsync@%0d", v.n), int'(vs_a), v.vs);
    chk($sformatf("a.video_on@%0d", v.n), int'(vo_a), v.vo);
    chk($sformatf("a.line_start@%0d", v.n), int'(ls_a), v.ls);
    chk($sformatf("a.frame_start@%0d", v.n), int'(fs_a), v.fs);
    chk($sformatf("a.frame_count@%0d", v.n), int'(fc_a), v.fc);
  endtask

  task automatic chk_b(input vec_t v);
    chk($sformatf("b.x@%0d", v.n), int'(x_b), v.x);
    chk($sformatf("b.y@%0d", v.n), int'(y_b), v.y);
    chk($sformatf("b.p_tick@%0d", v.n), int'(pt_b), v.pt);
    chk($sformatf("b.hsync@%0d", v.n), int'(hs_b), v.hs);
    chk($sformatf("b.vsync@%0d", v.n), int'(vs_b), v.vs);
    chk($sformatf("b.video_on@%0d", v.n), int'(vo_b), v.vo);
    chk($sformatf("b.line_start@%0d", v.n), int'(ls_b), v.ls);
    chk($sformatf("b.frame_start@%0d", v.n), int'(fs_b), v.fs);
    chk($sformatf("b.frame_count@%0d", v.n), int'(fc_b), v.fc);
  endtask

  initial begin
    // Raster: x 0..7 visible, 8..9 front, 10..12 sync, 13..14 back; y 0..3, 4, 5..6, 7.
    //              n    x  y pt hs vs vo ls fs fc
    tbl_a.push_back('{  0,  0, 0, 1, 1, 1, 0, 1, 1, 0});
    tbl_a.push_back('{  1,  1, 0, 1, 1, 1, 1, 0, 0, 0});
    tbl_a.push_back('{  8,  8, 0, 1, 1, 1, 1, 0, 0, 0});
    tbl_a.push_back('{  9,  9, 0, 1, 1, 1, 0, 0, 0, 0});
    tbl_a.push_back('{ 11, 11, 0, 1, 0, 1, 0, 0, 0, 0});
    tbl_a.push_back('{ 13, 13, 0, 1, 0, 1, 0, 0, 0, 0});
    tbl_a.push_back('{ 14, 14, 0, 1, 1, 1, 0, 0, 0, 0});
    tbl_a.push_back('{ 15,  0, 1, 1, 1, 1, 0, 1, 0, 0});
    tbl_a.push_back('{ 16,  1, 1, 1, 1, 1, 1, 0, 0, 0});
    tbl_a.push_back('{ 75,  0, 5, 1, 1, 1, 0, 1, 0, 0});
    tbl_a.push_back('{ 76,  1, 5, 1, 1, 0, 0, 0, 0, 0});
    tbl_a.push_back('{105,  0, 7, 1, 1, 0, 0, 1, 0, 0});
    tbl_a.push_back('{106,  1, 7, 1, 1, 1, 0, 0, 0, 0});
    tbl_a.push_back('{120,  0, 0, 1, 1, 1, 0, 1, 1, 1});
    tbl_a.push_back('{121,  1, 0, 1, 1, 1, 1, 0, 0, 1});
    tbl_a.push_back('{240,  0, 0, 1, 1, 1, 0, 1, 1, 2});
    // Divide-by-3 instance: n counts clk edges, a tick fires when n%3==2.
    tbl_b.push_back('{  0,  0, 0, 0, 0, 0, 0, 0, 0, 0});
    tbl_b.push_back('{  2,  0, 0, 1, 0, 0, 0, 1, 1, 0});
    tbl_b.push_back('{  3,  1, 0, 0, 0, 0, 0, 0, 0, 0});
    tbl_b.push_back('{  8,  2, 0, 1, 0, 0, 0, 0, 0, 0});
    tbl_b.push_back('{  9,  3, 0, 0, 0, 0, 1, 0, 0, 0});
    tbl_b.push_back('{ 37, 12, 0, 0, 0, 0, 0, 0, 0, 0});
    tbl_b.push_back('{ 39, 13, 0, 0, 1, 0, 0, 0, 0, 0});
    tbl_b.push_back('{ 45,  0, 1, 0, 1, 0, 0, 0, 0, 0});
    tbl_b.push_back('{ 48,  1, 1, 0, 0, 0, 0, 0, 0, 0});
    tbl_b.push_back('{231,  2, 5, 0, 0, 0, 0, 0, 0, 0});
    tbl_b.push_back('{234,  3, 5, 0, 0, 1, 0, 0, 0, 0});
    tbl_b.push_back('{360,  0, 0, 0, 1, 0, 0, 0, 0, 1});

    // Reset state of both instances, held in reset across clock edges.
    repeat (2) @(posedge clk);
    #2;
    chk("rst.a.x", int'(x_a), 0);
    chk("rst.a.hsync", int'(hs_a), 1);
    chk("rst.a.vsync", int'(vs_a), 1);
    chk("rst.a.video_on", int'(vo_a), 0);
    chk("rst.a.line_start", int'(ls_a), 0);
    chk("rst.b.hsync", int'(hs_b), 0);
    chk("rst.b.vsync", int'(vs_b), 0);
    chk("rst.b.frame_count", int'(fc_b), 0);

    do_reset();
    for (int i = 0; i < tbl_a.size(); i++) begin
      go_to(tbl_a[i].n);
      chk_a(tbl_a[i]);
    end

    do_reset();
    for (int i = 0; i < tbl_b.size(); i++) begin
      go_to(tbl_b[i].n);
      chk_b(tbl_b[i]);
    end

    // Freeze exactly at a line start: no strobe while disabled, resumes without loss.
    do_reset();
    go_to(15);
    enable = 1'b0;
    #1;
    chk("frz.p_tick", int'(pt_a), 0);
    chk("frz.line_start", int'(ls_a), 0);
    for (int i = 0; i < 20; i++) adv();
    chk("frz.x", int'(x_a), 0);
    chk("frz.y", int'(y_a), 1);
    chk("frz.hsync", int'(hs_a), 1);
    chk("frz.line_start_held", int'(ls_a), 0);
    chk("frz.b.x", int'(x_b), 5);
    enable = 1'b1;
    #1;
    chk("resume.line_start", int'(ls_a), 1);
    adv();
    chk("resume.x", int'(x_a), 1);
    chk("resume.y", int'(y_a), 1);
    chk("resume.video_on", int'(vo_a), 1);

    // Asynchronous reset mid-frame inside vertical sync of the second frame.
    do_reset();
    go_to(220);
    chk("mid.pre.x", int'(x_a), 10);
    chk("mid.pre.vsync", int'(vs_a), 0);
    chk("mid.pre.frame_count", int'(fc_a), 1);
    #2;
    reset = 1'b1;
    #1;
    chk("mid.rst.x", int'(x_a), 0);
    chk("mid.rst.y", int'(y_a), 0);
    chk("mid.rst.vsync", int'(vs_a), 1);
    chk("mid.rst.hsync", int'(hs_a), 1);
    chk("mid.rst.video_on", int'(vo_a), 0);
    chk("mid.rst.frame_count", int'(fc_a), 0);
    chk("mid.rst.frame_start", int'(fs_a), 0);
    @(posedge clk);
    #2;
    reset = 1'b0;
    edges = 0;
    #1;
    chk("mid.rel.frame_start", int'(fs_a), 1);
    adv();
    chk("mid.rel.x", int'(x_a), 1);
    chk("mid.rel.y", int'(y_a), 0);
    chk("mid.rel.frame_count", int'(fc_a), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
